// File: rtl/vic_irq_prio.sv
// Vectored interrupt controller with per-source trigger modes, priority arbitration and
// nested in-service tracking so higher-priority sources can preempt a running handler.
module vic_irq_prio #(
  parameter int unsigned N_SRC  = 31,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PRIO_W = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [N_SRC-1:0]         i_ext,
  input  logic [4*N_SRC-1:0]       i_reg,
  input  logic [PRIO_W*N_SRC-1:0]  i_prio,
  input  logic                     i_ack,
  input  logic                     i_eoi,
  output logic                     o_IRQ,
  output logic [ADDR_W-1:0]        o_irq_addr,
  output logic [N_SRC-1:0]         o_pending,
  output logic [2**PRIO_W-1:0]     o_insvc
);

  localparam int unsigned NumLvl = 2 ** PRIO_W;

  typedef enum logic {StIdle, StAssert} state_e;

  state_e              state_q, state_d;
  logic [N_SRC-1:0]    prev_q, pend_q, pend_d, rise, fall;
  logic [NumLvl-1:0]   insvc_q, insvc_d, insvc_top;
  logic [ADDR_W-1:0]   addr_q, addr_d, win_idx;
  logic [PRIO_W-1:0]   req_prio_q, req_prio_d, win_prio;
  logic                win_valid, eligible, ack_take, latched_pend;

  assign rise     = i_ext & ~prev_q;
  assign fall     = ~i_ext & prev_q;
  assign ack_take = (state_q == StAssert) && i_ack;

  // Strict '>' keeps the lowest index on priority ties.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      if (pend_q[k] && (!win_valid || i_prio[PRIO_W*k +: PRIO_W] > win_prio)) begin
        win_valid = 1'b1;
        win_idx   = ADDR_W'(k);
        win_prio  = i_prio[PRIO_W*k +: PRIO_W];
      end
    end
  end

  always_comb begin
    insvc_top = '0;
    for (int i = 0; i < int'(NumLvl); i++) begin
      if (insvc_q[i]) begin
        insvc_top    = '0;
        insvc_top[i] = 1'b1;
      end
    end
  end

  always_comb begin
    latched_pend = 1'b0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      if (addr_q == ADDR_W'(k)) latched_pend = pend_q[k];
    end
  end

  // Eligible only if no in-service level is at or above the winner's priority.
  assign eligible = i_en && win_valid && ((insvc_q >> win_prio) == '0);

  always_comb begin
    pend_d = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      if (!i_reg[4*k+3]) begin
        pend_d[k] = 1'b0;
      end else if (i_reg[4*k]) begin
        pend_d[k] = i_ext[k];
      end else if ((i_reg[4*k+1] && rise[k]) || (i_reg[4*k+2] && fall[k])) begin
        pend_d[k] = 1'b1;
      end else begin
        pend_d[k] = pend_q[k] && !(ack_take && (addr_q == ADDR_W'(k)));
      end
    end
  end

  always_comb begin
    insvc_d = insvc_q;
    if (i_eoi) insvc_d = insvc_q & ~insvc_top;
    if (ack_take) insvc_d[req_prio_q] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_prio_d = req_prio_q;
    unique case (state_q)
      StIdle: begin
        if (eligible) begin
          state_d    = StAssert;
          addr_d     = win_idx;
          req_prio_d = win_prio;
        end
      end
      StAssert: begin
        if (ack_take || !latched_pend || !i_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= StIdle;
      prev_q     <= '0;
      pend_q     <= '0;
      insvc_q    <= '0;
      addr_q     <= '0;
      req_prio_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= i_ext;
      pend_q     <= pend_d;
      insvc_q    <= insvc_d;
      addr_q     <= addr_d;
      req_prio_q <= req_prio_d;
    end
  end

  assign o_IRQ      = (state_q == StAssert);
  assign o_irq_addr = addr_q;
  assign o_pending  = pend_q;
  assign o_insvc    = insvc_q;

endmodule

// File: tb/tb_vic_irq_prio.sv
// Bench for vic_irq_prio: directed scenarios plus random traffic, checked every cycle against
// a rule-level reference model through an expected-value queue.
module tb_vic_irq_prio;

  localparam int N = 31;

  logic           clk = 1'b0;
  logic           rst_v, en_v, ack_v, eoi_v;
  logic [N-1:0]   ext_v;
  logic [4*N-1:0] reg_v;
  logic [2*N-1:0] prio_v;
  logic           irq;
  logic [4:0]     addr;
  logic [N-1:0]   pend;
  logic [3:0]     insvc;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic         irq;
    logic [4:0]   addr;
    logic [N-1:0] pend;
    logic [3:0]   insvc;
  } snap_t;

  snap_t exp_q[$];

  // Reference model state
  bit           m_busy;
  int           m_addr, m_req;
  bit [N-1:0]   m_pend, m_prev;
  bit [3:0]     m_insvc;

  vic_irq_prio #(.N_SRC(N), .ADDR_W(5), .PRIO_W(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst_v),
    .i_en       (en_v),
    .i_ext      (ext_v),
    .i_reg      (reg_v),
    .i_prio     (prio_v),
    .i_ack      (ack_v),
    .i_eoi      (eoi_v),
    .o_IRQ      (irq),
    .o_irq_addr (addr),
    .o_pending  (pend),
    .o_insvc    (insvc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int prio_of(int k);
    return int'(prio_v[2*k +: 2]);
  endfunction

  // Apply one clock edge worth of the controller's rules to the model, queue the outcome.
  task automatic model_step();
    int best, lvl;
    bit acked;
    bit [N-1:0] np;
    bit [3:0] ni;
    bit [3:0] cfg;
    if (!rst_v) begin
      m_busy = 0; m_addr = 0; m_req = 0; m_pend = '0; m_prev = '0; m_insvc = '0;
    end else begin
      best = -1;
      for (int k = 0; k < N; k++)
        if (m_pend[k] && (best < 0 || prio_of(k) > prio_of(best))) best = k;
      lvl = -1;
      for (int i = 0; i < 4; i++) if (m_insvc[i]) lvl = i;
      acked = m_busy && ack_v;
      ni = m_insvc;
      if (eoi_v && lvl >= 0) ni[lvl] = 1'b0;
      if (acked) ni[m_req] = 1'b1;
      for (int k = 0; k < N; k++) begin
        cfg = reg_v[4*k +: 4];
        if (!cfg[3]) np[k] = 0;
        else if (cfg[0]) np[k] = ext_v[k];
        else if ((cfg[1] && ext_v[k] && !m_prev[k]) || (cfg[2] && !ext_v[k] && m_prev[k]))
          np[k] = 1;
        else if (acked && m_addr == k) np[k] = 0;
        else np[k] = m_pend[k];
      end
      if (!m_busy) begin
        if (en_v && best >= 0 && prio_of(best) > lvl) begin
          m_busy = 1; m_addr = best; m_req = prio_of(best);
        end
      end else if (acked || !m_pend[m_addr] || !en_v) begin
        m_busy = 0;
      end
      m_pend  = np;
      m_insvc = ni;
      m_prev  = ext_v;
    end
    exp_q.push_back('{m_busy, 5'(m_addr), m_pend, m_insvc});
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_src(int k, bit en, bit fall, bit rise, bit lvl, int p);
    reg_v[4*k +: 4] = {en, fall, rise, lvl};
    prio_v[2*k +: 2] = 2'(p);
  endtask

  task automatic pulse_ack();
    ack_v = 1'b1; step(); ack_v = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi_v = 1'b1; step(); eoi_v = 1'b0;
  endtask

  task automatic clean();
    reg_v = '0; ext_v = '0;
    step(); step();
    repeat (4) pulse_eoi();
  endtask

  // Monitor: the DUT presents its full state after every edge.
  always @(posedge clk) begin
    snap_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("irq", 64'(irq), 64'(e.irq));
      chk("addr", 64'(addr), 64'(e.addr));
      chk("pending", 64'(pend), 64'(e.pend));
      chk("insvc", 64'(insvc), 64'(e.insvc));
    end
  end

  initial begin
    rst_v = 1'b0; en_v = 1'b1; ack_v = 1'b0; eoi_v = 1'b0;
    ext_v = '0; reg_v = '0; prio_v = '0;
    @(negedge clk);
    step(); step();
    chk("reset_irq", 64'(irq), 0);
    chk("reset_insvc", 64'(insvc), 0);
    rst_v = 1'b1;
    step();

    // Rise-mode source 3
    set_src(3, 1, 0, 1, 0, 1);
    step();
    ext_v[3] = 1'b1; step();
    chk("t1_pend", 64'(pend[3]), 1);
    chk("t1_irq_early", 64'(irq), 0);
    step();
    chk("t1_irq", 64'(irq), 1);
    chk("t1_addr", 64'(addr), 3);
    step();
    pulse_ack();
    chk("t1_ack_irq", 64'(irq), 0);
    chk("t1_ack_insvc", 64'(insvc), 64'b0010);
    chk("t1_ack_pend", 64'(pend[3]), 0);
    clean();

    // Priority and in-service blocking
    set_src(2, 1, 0, 1, 0, 1);
    set_src(7, 1, 0, 1, 0, 3);
    ext_v[2] = 1'b1; ext_v[7] = 1'b1; step();
    step();
    chk("t2_addr7", 64'(addr), 7);
    pulse_ack();
    chk("t2_insvc", 64'(insvc), 64'b1000);
    step(); step();
    chk("t2_blocked", 64'(irq), 0);
    pulse_eoi();
    chk("t2_eoi_irq", 64'(irq), 0);
    step();
    chk("t2_irq2", 64'(irq), 1);
    chk("t2_addr2", 64'(addr), 2);
    pulse_ack();
    pulse_eoi();
    chk("t2_insvc_end", 64'(insvc), 0);
    clean();

    // Nesting
    set_src(5, 1, 0, 1, 0, 1);
    set_src(9, 1, 0, 1, 0, 2);
    ext_v[5] = 1'b1; step(); step();
    chk("t3_addr5", 64'(addr), 5);
    pulse_ack();
    ext_v[9] = 1'b1; step(); step();
    chk("t3_irq9", 64'(irq), 1);
    chk("t3_addr9", 64'(addr), 9);
    pulse_ack();
    chk("t3_insvc_0110", 64'(insvc), 64'b0110);
    pulse_eoi();
    chk("t3_insvc_0010", 64'(insvc), 64'b0010);
    pulse_eoi();
    chk("t3_insvc_0", 64'(insvc), 0);
    clean();

    // Level withdrawal, fall mode, both edges
    set_src(4, 1, 0, 0, 1, 1);
    ext_v[4] = 1'b1; step(); step();
    chk("t4_addr4", 64'(addr), 4);
    ext_v[4] = 1'b0; step();
    chk("t4_pend_drop", 64'(pend[4]), 0);
    chk("t4_irq_hold", 64'(irq), 1);
    step();
    chk("t4_irq_drop", 64'(irq), 0);
    chk("t4_insvc", 64'(insvc), 0);
    set_src(10, 1, 1, 0, 0, 1);
    ext_v[10] = 1'b1; step();
    chk("t4_fall_rise", 64'(pend[10]), 0);
    ext_v[10] = 1'b0; step();
    chk("t4_fall_fall", 64'(pend[10]), 1);
    step(); pulse_ack(); pulse_eoi();
    set_src(11, 1, 1, 1, 0, 1);
    ext_v[11] = 1'b1; step();
    chk("t4_both_rise", 64'(pend[11]), 1);
    step(); pulse_ack(); pulse_eoi();
    ext_v[11] = 1'b0; step();
    chk("t4_both_fall", 64'(pend[11]), 1);
    step(); pulse_ack(); pulse_eoi();
    clean();

    // Tie, disabled source, global enable, reset mid-request
    set_src(0, 1, 0, 1, 0, 2);
    set_src(6, 1, 0, 1, 0, 2);
    set_src(12, 0, 0, 1, 0, 3);
    ext_v[0] = 1'b1; ext_v[6] = 1'b1; ext_v[12] = 1'b1; step();
    chk("t5_disabled", 64'(pend[12]), 0);
    step();
    chk("t5_tie", 64'(addr), 0);
    en_v = 1'b0; step();
    chk("t6_en_off", 64'(irq), 0);
    chk("t6_pend_kept", 64'(pend[0]), 1);
    en_v = 1'b1; step();
    chk("t6_reassert", 64'(irq), 1);
    chk("t6_readdr", 64'(addr), 0);
    pulse_ack(); pulse_eoi(); step();
    chk("t6_addr6", 64'(addr), 6);
    rst_v = 1'b0; step();
    chk("t6_rst_irq", 64'(irq), 0);
    chk("t6_rst_addr", 64'(addr), 0);
    chk("t6_rst_pend", 64'(pend), 0);
    rst_v = 1'b1;
    clean();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0)
        for (int k = 0; k < N; k++) begin
          reg_v[4*k +: 4] = 4'($urandom);
          prio_v[2*k +: 2] = 2'($urandom);
        end
      ext_v ^= N'($urandom & $urandom & $urandom & $urandom);
      ack_v = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      eoi_v = ($urandom_range(0, 15) == 0);
      en_v  = ($urandom_range(0, 31) != 0);
      rst_v = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_v = 1'b1; ack_v = 1'b0; eoi_v = 1'b0; en_v = 1'b1;

    @(posedge clk);
    #2;
    chk("drain", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vic_irq_prio.md
# vic_irq_prio

Parametrised, priority-nesting successor to the vectored interrupt controller. It accepts `N_SRC` external interrupt lines, each with its own enable, trigger mode (level / rise / fall) and priority, and latches edge events into pending bits. It arbitrates among the requesting sources and presents a single `o_IRQ` request plus vector address to the CPU. An ack/EOI handshake and an in-service mask allow higher-priority sources to preempt a running handler.

## Interface
- `N_SRC`, 31, number of interrupt sources (1..64)
- `ADDR_W`, 5, vector address width; `2**ADDR_W >= N_SRC` is required
- `PRIO_W`, 2, priority field width; higher value = higher priority
- `i_clk`  in  1  clock, all logic on rising edge
- `i_rst`  in  1  reset, synchronous, active-low
- `i_en`  in  1  global enable
- `i_ext`  in  N_SRC  raw interrupt lines, synchronous to `i_clk`
- `i_reg`  in  4*N_SRC  per-source config, source k: [4k+3]=en, [4k+2]=fall, [4k+1]=rise, [4k]=level
- `i_prio`  in  PRIO_W*N_SRC  per-source priority, source k at [PRIO_W*k +: PRIO_W]
- `i_ack`  in  1  CPU accepts current vector (1-cycle pulse)
- `i_eoi`  in  1  CPU finished the highest in-service handler (1-cycle pulse)
- `o_IRQ`  out  1  interrupt request to CPU
- `o_irq_addr`  out  ADDR_W  vector (source index) of the request
- `o_pending`  out  N_SRC  registered request bits
- `o_insvc`  out  2**PRIO_W  in-service mask, one bit per priority level

## Operation
- `prev` register holds `i_ext` from the previous edge; rise = `i_ext & ~prev`, fall = `~i_ext & prev`.
- Pending, per source, when en=1:
  - level=1: pending := `i_ext[k]` every cycle. Level overrides the rise/fall bits.
  - Otherwise pending is set on a qualified rise (rise bit) or fall (fall bit); both bits set = both edges.
  - Edge pending clears on `i_ack` when k is the latched vector. A new qualifying edge in the same cycle wins, so pending stays 1.
  - en=0 forces pending 0.
- Arbitration (combinational over pending): highest `i_prio` wins; ties go to the lowest index.
- Current level L = index of the highest set bit of `o_insvc`, or -1 if the mask is empty.
- A winner is eligible when `i_en`=1 and winner prio > L.
- FSM:
  - IDLE: `o_IRQ`=0. On an eligible winner go to ASSERT, latch the winner into `o_irq_addr` and its prio into `req_prio`.
  - ASSERT: `o_IRQ`=1. `o_irq_addr` is frozen; a later higher-priority arrival does not replace it.
    - `i_ack`: set `o_insvc[req_prio]`, clear the edge pending bit, go to IDLE.
    - Latched source's pending drops before ack (level released, en cleared), or `i_en`=0: go to IDLE, no in-service change.
- `i_eoi`: clear the highest set bit of `o_insvc`. Ignored if the mask is empty.
- `i_ack` and `i_eoi` in the same cycle: EOI is applied first, then ACK sets its bit.
- `i_ack` in IDLE: ignored.
- `i_en`=0: `o_IRQ` goes low; pending and `o_insvc` are retained (except per-source en gating).

## Timing
- Reset (`i_rst`=0 at an edge): `prev`, pending, `o_insvc`, `req_prio` = 0; FSM = IDLE; `o_IRQ`=0; `o_irq_addr`=0. Reset mid-ASSERT drops the request at that edge.
- Latency: `i_ext` changes before edge k → pending set at edge k → `o_IRQ`=1 and `o_irq_addr` valid at edge k+1. Two cycles for all modes.
- ACK sampled at edge a: `o_IRQ`=0 after edge a. The earliest re-assert is edge a+1 (at least one low cycle between requests).
- Withdrawal: pending drops at edge w → `o_IRQ`=0 after edge w+1.
- `o_insvc` updates at the ACK/EOI edge. Preemption eligibility uses the updated mask from the next cycle.

## Test plan
- Source 3 in rise mode, prio 1, `i_ext[3]` 0→1 before edge 10 → `o_pending[3]`=1 at edge 10; `o_IRQ`=1, `o_irq_addr`=3 at edge 11; ack at edge 13 → `o_IRQ`=0, `o_insvc`=4'b0010, `o_pending[3]`=0.
- Sources 2 (prio 1) and 7 (prio 3) rise on the same cycle → vector 7 first; after its ack, source 2 is blocked (1 < 3). EOI → vector 2 is asserted 2 edges later.
- Nesting: source 5 (prio 1) in service, then source 9 (prio 2) edge → `o_IRQ` with vector 9. Ack → `o_insvc`=4'b0110; first EOI → 4'b0010; second EOI → 0.
- Level source 4 held high, then dropped before ack → `o_IRQ` falls one cycle after pending clears, `o_insvc` unchanged. A fall-mode source 1→0 edge and a both-edges source produce pending on the correct transitions.
- Tie: sources 0 and 6, both prio 2, simultaneous → vector 0. Disabled source (en=0) edge → no pending, no `o_IRQ`.
- `i_en`=0 during ASSERT → `o_IRQ`=0 next edge; re-enable → same vector reasserted. `i_rst`=0 mid-ASSERT → all outputs 0 at that edge.
